// File: rtl/audio_sd_pkg.sv
// Shared constants and helpers for the N-channel sigma-delta audio modulator.
// Holds the dither LFSR seeds/taps and a generic sign-extension helper.
package audio_sd_pkg;

    localparam logic [23:0] SEED1_INIT = 24'h654321;
    localparam logic [18:0] SEED2_INIT = 19'h12345;

    // Sign-extend the low w bits of v to 32 bits.
    function automatic logic signed [31:0] sext(input logic [31:0] v, input int w);
        return $signed(v << (32 - w)) >>> (32 - w);
    endfunction

    // An all-ones state would lock the XNOR LFSR, so it reloads the seed.
    function automatic logic [23:0] lfsr24_next(input logic [23:0] s);
        return (s == '1) ? SEED1_INIT : {s[22:0], ~(s[23] ^ s[22] ^ s[21] ^ s[16])};
    endfunction

    function automatic logic [18:0] lfsr19_next(input logic [18:0] s);
        return (s == '1) ? SEED2_INIT : {s[17:0], ~(s[18] ^ s[17] ^ s[16] ^ s[13] ^ s[0])};
    endfunction

endpackage

// File: rtl/audio_sd_channel.sv
// One modulator channel: linear interpolator, x3 gain, 1st/2nd-order loop
// and registered 1-bit output. Advances only on clk_en.
module audio_sd_channel
    import audio_sd_pkg::*;
#(
    parameter int DW  = 15,
    parameter int ID  = 4,
    parameter int A1W = 2,
    parameter int A2W = 5,
    parameter int RW  = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clk_en,
    input  logic          load,
    input  logic          clr,
    input  logic          order2_q,
    input  logic          mute,
    input  logic [RW-1:0] dith,
    input  logic [DW-1:0] data,
    output logic          sd_out
);

    localparam int IW = DW + ID + 1;
    localparam int GW = DW + 2;
    localparam int W1 = DW + A1W + 2;
    localparam int W2 = DW + A2W + 2;
    localparam int QW = W2 + 1;

    logic signed [DW-1:0] cur;
    logic signed [DW-1:0] prev;
    logic signed [IW-1:0] interp;
    logic signed [W1-1:0] ac1;
    logic signed [W2-1:0] ac2;
    logic signed [GW-1:0] er_prev;

    logic signed [DW:0]   step;
    logic signed [DW-1:0] int_hi;
    logic signed [GW-1:0] gain;
    logic signed [QW-1:0] dith_ext;
    logic signed [QW-1:0] q;
    logic                 q_msb;
    logic signed [GW-1:0] er;
    logic signed [GW-1:0] er_adj;
    logic signed [W1-1:0] ac1_next;
    logic signed [W2-1:0] ac2_next;

    assign step     = (DW+1)'(cur) - (DW+1)'(prev);
    assign int_hi   = interp[DW+ID-1:ID];
    assign gain     = (GW'(int_hi) <<< 1) + GW'(int_hi);
    assign dith_ext = QW'(sext(32'(dith), RW));
    assign q        = (order2_q ? QW'(ac2) : QW'(ac1)) + dith_ext;
    assign q_msb    = q[QW-1];

    // Full-scale feedback; the delayed copy is made symmetric before the half-weight tap.
    assign er       = q_msb ? {1'b1, {(GW-1){1'b0}}} : {1'b0, {(GW-1){1'b1}}};
    assign er_adj   = er + {{(GW-1){1'b0}}, q_msb};
    assign ac1_next = ac1 + W1'(gain) - W1'(er);
    assign ac2_next = ac2 + W2'(ac1_next) - W2'(er) - W2'(er_prev >>> 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur     <= '0;
            prev    <= '0;
            interp  <= '0;
            ac1     <= '0;
            ac2     <= '0;
            er_prev <= '0;
            sd_out  <= 1'b0;
        end else if (clk_en) begin
            if (load) begin
                prev   <= cur;
                cur    <= data;
                interp <= {(DW+1)'(cur), {ID{1'b0}}};
            end else begin
                interp <= interp + IW'(step);
            end
            if (mute || clr) begin
                ac1     <= '0;
                ac2     <= '0;
                er_prev <= '0;
            end else begin
                ac1     <= ac1_next;
                ac2     <= ac2_next;
                er_prev <= er_adj;
            end
            // Silent or muted channels idle at a 50% toggle rather than a stuck level.
            sd_out <= (mute || gain == '0) ? ~sd_out : ~q_msb;
        end
    end

endmodule

// File: rtl/audio_sigmadelta_nch.sv
// N-channel sigma-delta DAC modulator top: shared dither noise, interpolation
// phase counter, loop-order register and sample handshake around CH channels.
module audio_sigmadelta_nch
    import audio_sd_pkg::*;
#(
    parameter int CH  = 2,
    parameter int DW  = 15,
    parameter int ID  = 4,
    parameter int A1W = 2,
    parameter int A2W = 5,
    parameter int RW  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             order2,
    input  logic             dither_en,
    input  logic [CH-1:0]    mute,
    input  logic [CH*DW-1:0] data_in,
    output logic             sample_ack,
    output logic [CH-1:0]    sd_out
);

    logic [ID-1:0] cnt;
    logic [23:0]   seed1;
    logic [18:0]   seed2;
    logic [23:0]   seed_sum;
    logic [23:0]   seed_prev;
    logic [RW-1:0] seed_out;
    logic          order2_q;

    logic          load;
    logic          clr;
    logic [RW-1:0] dith;

    assign load = (cnt == '0);
    assign clr  = (order2 != order2_q);
    assign dith = dither_en ? seed_out : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            sample_ack <= 1'b0;
            seed1      <= SEED1_INIT;
            seed2      <= SEED2_INIT;
            seed_sum   <= '0;
            seed_prev  <= '0;
            seed_out   <= '0;
            order2_q   <= 1'b0;
        end else begin
            sample_ack <= 1'b0;
            if (clk_en) begin
                cnt        <= cnt + ID'(1);
                sample_ack <= load;
                seed1      <= lfsr24_next(seed1);
                seed2      <= lfsr19_next(seed2);
                seed_sum   <= seed1 + 24'(seed2);
                seed_prev  <= seed_sum;
                // First difference high-passes the noise; only the dither bits are kept.
                seed_out   <= RW'(seed_sum - seed_prev);
                order2_q   <= order2;
            end
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_ch
        audio_sd_channel #(
            .DW (DW),
            .ID (ID),
            .A1W(A1W),
            .A2W(A2W),
            .RW (RW)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .clk_en  (clk_en),
            .load    (load),
            .clr     (clr),
            .order2_q(order2_q),
            .mute    (mute[k]),
            .dith    (dith),
            .data    (data_in[k*DW +: DW]),
            .sd_out  (sd_out[k])
        );
    end

endmodule

// File: tb/tb_audio_sigmadelta_nch.sv
// Randomised bench for audio_sigmadelta_nch against an integer-arithmetic
// reference of the modulator, plus density and async-reset checks.
module tb_audio_sigmadelta_nch;

    localparam int CH  = 2;
    localparam int DW  = 15;
    localparam int ID  = 4;
    localparam int A1W = 2;
    localparam int A2W = 5;
    localparam int RW  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             clk_en;
    logic             order2;
    logic             dither_en;
    logic [CH-1:0]    mute;
    logic [CH*DW-1:0] data_in;
    logic             sample_ack;
    logic [CH-1:0]    sd_out;

    int n_vec = 0;
    int n_err = 0;

    // reference state
    longint m_cur [CH];
    longint m_prv [CH];
    longint m_itp [CH];
    longint m_a1  [CH];
    longint m_a2  [CH];
    longint m_ep  [CH];
    bit     m_sd  [CH];
    longint m_s1, m_s2, m_sum, m_sprev, m_sout;
    int     m_cnt;
    bit     m_o2q;
    bit     m_ack;

    audio_sigmadelta_nch #(
        .CH(CH), .DW(DW), .ID(ID), .A1W(A1W), .A2W(A2W), .RW(RW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .order2    (order2),
        .dither_en (dither_en),
        .mute      (mute),
        .data_in   (data_in),
        .sample_ack(sample_ack),
        .sd_out    (sd_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, $signed(obs), $signed(exp), $time);
        end
    endtask

    function automatic longint wrap(input longint x, input int w);
        longint m;
        m = longint'(1) << w;
        x = x & (m - 1);
        if (x >= (m >>> 1)) x = x - m;
        return x;
    endfunction

    function automatic longint lfsr1(input longint s);
        if (s == 64'hFFFFFF) return 64'h654321;
        return ((s << 1) | (~((s >> 23) ^ (s >> 22) ^ (s >> 21) ^ (s >> 16)) & 1)) & 64'hFFFFFF;
    endfunction

    function automatic longint lfsr2(input longint s);
        if (s == 64'h7FFFF) return 64'h12345;
        return ((s << 1) | (~((s >> 18) ^ (s >> 17) ^ (s >> 16) ^ (s >> 13) ^ s) & 1)) & 64'h7FFFF;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < CH; k++) begin
            m_cur[k] = 0; m_prv[k] = 0; m_itp[k] = 0;
            m_a1[k] = 0;  m_a2[k] = 0;  m_ep[k] = 0; m_sd[k] = 0;
        end
        m_s1 = 64'h654321; m_s2 = 64'h12345;
        m_sum = 0; m_sprev = 0; m_sout = 0;
        m_cnt = 0; m_o2q = 0; m_ack = 0;
    endtask

    task automatic model_tick();
        longint dith, g, q, er, n1, n2, nsum, full;
        bit clr, neg;
        full = longint'(1) << (DW + 1);
        dith = m_sout & ((1 << RW) - 1);
        if (dith >= (1 << (RW - 1))) dith = dith - (1 << RW);
        if (!dither_en) dith = 0;
        clr = (order2 != m_o2q);
        for (int k = 0; k < CH; k++) begin
            g   = 3 * (m_itp[k] >>> ID);
            q   = (m_o2q ? m_a2[k] : m_a1[k]) + dith;
            neg = (q < 0);
            er  = neg ? -full : full - 1;
            m_sd[k] = (mute[k] || g == 0) ? !m_sd[k] : !neg;
            if (mute[k] || clr) begin
                m_a1[k] = 0; m_a2[k] = 0; m_ep[k] = 0;
            end else begin
                n1 = wrap(m_a1[k] + g - er, DW + A1W + 2);
                n2 = wrap(m_a2[k] + n1 - er - (m_ep[k] >>> 1), DW + A2W + 2);
                m_a1[k] = n1;
                m_a2[k] = n2;
                m_ep[k] = er + (neg ? 1 : 0);
            end
            if (m_cnt == 0) begin
                m_itp[k] = m_cur[k] * (1 << ID);
                m_prv[k] = m_cur[k];
                m_cur[k] = longint'($signed(data_in[k*DW +: DW]));
            end else begin
                m_itp[k] = m_itp[k] + (m_cur[k] - m_prv[k]);
            end
        end
        m_ack = (m_cnt == 0);
        m_cnt = (m_cnt + 1) % (1 << ID);
        nsum    = (m_s1 + m_s2) & 64'hFFFFFF;
        m_sout  = (m_sum - m_sprev) & 64'hFFFFFF;
        m_sprev = m_sum;
        m_sum   = nsum;
        m_s1    = lfsr1(m_s1);
        m_s2    = lfsr2(m_s2);
        m_o2q   = order2;
    endtask

    // Called at a negedge with inputs set; returns at the following negedge.
    task automatic tick(input bit en);
        logic [CH-1:0] exp_sd;
        clk_en = en;
        @(posedge clk);
        #1;
        if (en) model_tick();
        else m_ack = 0;
        for (int k = 0; k < CH; k++) exp_sd[k] = m_sd[k];
        check_val("sd_out", 64'(sd_out), 64'(exp_sd));
        check_val("sample_ack", 64'(sample_ack), 64'(m_ack));
        check_val("interp_ch0", 64'($signed(dut.g_ch[0].u_ch.interp)), m_itp[0]);
        check_val("interp_ch1", 64'($signed(dut.g_ch[1].u_ch.interp)), m_itp[1]);
        check_val("ac1_ch0", 64'($signed(dut.g_ch[0].u_ch.ac1)), m_a1[0]);
        check_val("ac1_ch1", 64'($signed(dut.g_ch[1].u_ch.ac1)), m_a1[1]);
        check_val("ac2_ch0", 64'($signed(dut.g_ch[0].u_ch.ac2)), m_a2[0]);
        check_val("ac2_ch1", 64'($signed(dut.g_ch[1].u_ch.ac2)), m_a2[1]);
        @(negedge clk);
    endtask

    initial begin
        int ones;
        int exp_ones;
        int tol;

        reset = 1'b1; clk_en = 1'b0; order2 = 1'b0; dither_en = 1'b0;
        mute = '0; data_in = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_val("reset_sd", 64'(sd_out), 64'd0);
        check_val("reset_ack", 64'(sample_ack), 64'd0);
        reset = 1'b0;

        // idle: zero input toggles, ack once per 16 ticks
        for (int i = 1; i <= 64; i++) begin
            tick(1'b1);
            check_val("idle_toggle", 64'(sd_out[0]), 64'(i % 2));
            check_val("idle_ack", 64'(sample_ack), 64'(((i - 1) % 16) == 0));
        end

        // step on channel 0 only, second-order loop
        order2 = 1'b1;
        data_in[0 +: DW] = 15'h2000;
        for (int i = 0; i < 48; i++) tick(1'b1);

        // randomised traffic with gaps, order/mute/dither changes
        for (int i = 0; i < 2000; i++) begin
            for (int k = 0; k < CH; k++) data_in[k*DW +: DW] = DW'($urandom);
            if ($urandom_range(0, 63) == 0) order2 = ~order2;
            if ($urandom_range(0, 31) == 0) mute = CH'($urandom);
            if ($urandom_range(0, 127) == 0) dither_en = ~dither_en;
            tick($urandom_range(0, 3) != 0);
        end

        // mute channel 1 at full scale, then release
        mute = 2'b10; order2 = 1'b1; dither_en = 1'b1;
        for (int k = 0; k < CH; k++) data_in[k*DW +: DW] = 15'h3FFF;
        for (int i = 0; i < 64; i++) tick(1'b1);
        mute = '0;
        for (int i = 0; i < 256; i++) tick(1'b1);

        // ones density for a constant input, dither off
        dither_en = 1'b0;
        for (int k = 0; k < CH; k++) data_in[k*DW +: DW] = 15'h1000;
        for (int i = 0; i < 64; i++) tick(1'b1);
        ones = 0;
        for (int i = 0; i < 4096; i++) begin
            tick(1'b1);
            ones += int'(sd_out[0]);
        end
        exp_ones = 2048 + (3 * 4096 * 4096) / (1 << 17);
        tol = 4096 / 200;
        check_val("density_in_range", 64'((ones >= exp_ones - tol) && (ones <= exp_ones + tol)), 64'd1);

        // async reset between edges
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_val("async_rst_sd", 64'(sd_out), 64'd0);
        check_val("async_rst_ack", 64'(sample_ack), 64'd0);
        check_val("async_rst_seed1", 64'(dut.seed1), 64'h654321);
        check_val("async_rst_seed2", 64'(dut.seed2), 64'h12345);
        check_val("async_rst_cnt", 64'(dut.cnt), 64'd0);
        check_val("async_rst_ac2", 64'($signed(dut.g_ch[0].u_ch.ac2)), 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 200; i++) begin
            for (int k = 0; k < CH; k++) data_in[k*DW +: DW] = DW'($urandom);
            if ($urandom_range(0, 31) == 0) order2 = ~order2;
            tick($urandom_range(0, 4) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
